// File: rtl/bird_motion.sv
// bird_motion: bird vertical physics, wall/floor collision and IDLE/FLY/DEAD control; every output updates one clk after its cause.
// Build option CEILING_KILL_EN: touching the ceiling kills the bird instead of stopping it.
module bird_motion #(
  parameter int SCREEN_H     = 120,
  parameter int BIRD_H       = 4,
  parameter int BIRD_X       = 20,
  parameter int Y_START      = 60,
  parameter int GRAVITY      = 1,
  parameter int FLAP_IMPULSE = 6,
  parameter int MAX_FALL_V   = 7,
  parameter int GAP_H        = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_top,
  output logic [6:0] bird_y,
  output logic [4:0] bird_vy,
  output logic [1:0] state,
  output logic       collision
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FLY     = 2'b01,
    DEAD    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic signed [9:0] GRAV_S  = 10'(GRAVITY);
  localparam logic signed [9:0] MAX_V_S = 10'(MAX_FALL_V);
  localparam logic signed [9:0] FLAP_V  = 10'(-FLAP_IMPULSE);
  localparam logic signed [9:0] FLOOR_S = 10'(SCREEN_H - BIRD_H);
  localparam logic [6:0]        FLOOR_Y = 7'(SCREEN_H - BIRD_H);
  localparam logic [6:0]        Y_INIT  = 7'(Y_START);
  localparam logic [8:0]        X_LEFT  = 9'(BIRD_X);
  localparam logic [8:0]        X_RIGHT = 9'(BIRD_X + 3);

  state_t st;
  logic   flap_q;
  logic   flap_pend;
  logic   flap_edge;

  logic signed [9:0] vy_cur;
  logic signed [9:0] vy_fall;
  logic signed [9:0] vy_next;
  logic signed [9:0] y_sum;
  logic [8:0]        wall_r;
  logic [7:0]        bird_bot;
  logic [7:0]        gap_bot;
  logic              wall_hit;

  assign state     = st;
  assign flap_edge = flap & ~flap_q;

  always_comb begin
    vy_cur  = $signed({{5{bird_vy[4]}}, bird_vy});
    vy_fall = vy_cur + GRAV_S;
    if (vy_fall > MAX_V_S)
      vy_fall = MAX_V_S;
    // an edge arriving on the tick cycle counts as pending
    vy_next = (flap_pend | flap_edge) ? FLAP_V : vy_fall;
    y_sum   = $signed({3'b000, bird_y}) + vy_next;
  end

  always_comb begin
    wall_r   = {1'b0, wall_x} + 9'd3;
    bird_bot = {1'b0, bird_y} + 8'(BIRD_H);
    gap_bot  = {1'b0, gap_top} + 8'(GAP_H);
    wall_hit = (X_RIGHT >= {1'b0, wall_x}) && (X_LEFT <= wall_r) &&
               ((bird_y < gap_top) || (bird_bot > gap_bot));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st        <= IDLE;
      bird_y    <= Y_INIT;
      bird_vy   <= '0;
      collision <= 1'b0;
      flap_pend <= 1'b0;
      flap_q    <= 1'b0;
    end else begin
      flap_q <= flap;
      case (st)
        IDLE: begin
          bird_y    <= Y_INIT;
          bird_vy   <= '0;
          collision <= 1'b0;
          flap_pend <= 1'b0;
          if (flap_edge)
            st <= FLY;
        end
        FLY: begin
          // a wall hit freezes motion even if a tick lands on the same cycle
          if (wall_hit) begin
            collision <= 1'b1;
            flap_pend <= 1'b0;
            st        <= DEAD;
          end else begin
            if (flap_edge)
              flap_pend <= 1'b1;
            if (frame_tick) begin
              flap_pend <= 1'b0;
              if (y_sum >= FLOOR_S) begin
                bird_y    <= FLOOR_Y;
                bird_vy   <= vy_next[4:0];
                collision <= 1'b1;
                st        <= DEAD;
              end else if (y_sum < 10'sd0) begin
                bird_y <= '0;
`ifdef CEILING_KILL_EN
                bird_vy   <= vy_next[4:0];
                collision <= 1'b1;
                st        <= DEAD;
`else
                bird_vy <= '0;
`endif
              end else begin
                bird_y  <= y_sum[6:0];
                bird_vy <= vy_next[4:0];
              end
            end
          end
        end
        DEAD: begin
          collision <= 1'b1;
          if (flap_edge) begin
            st        <= IDLE;
            bird_y    <= Y_INIT;
            bird_vy   <= '0;
            collision <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          bird_y    <= Y_INIT;
          bird_vy   <= '0;
          collision <= 1'b0;
          flap_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 Parameter SCREEN_H, default 120, playfield height in pixels.
REQ-002 Parameter BIRD_H, default 4, bird sprite height in pixels.
REQ-003 Parameter BIRD_X, default 20, fixed bird column; bird is 4 px wide.
REQ-004 Parameter Y_START, default 60, bird row in IDLE.
REQ-005 Parameter GRAVITY, default 1, velocity increment per frame.
REQ-006 Parameter FLAP_IMPULSE, default 6, upward velocity magnitude applied on a flap.
REQ-007 Parameter MAX_FALL_V, default 7, maximum downward velocity.
REQ-008 Parameter GAP_H, default 30, wall gap height in pixels.
REQ-009 clk  input  1  system clock; all state updates on the rising edge.
REQ-010 resetn  input  1  reset, synchronous, active-low.
REQ-011 frame_tick  input  1  one-cycle pulse, once per frame.
REQ-012 flap  input  1  player button level, active-high, synchronous to clk.
REQ-013 wall_x  input  8  current wall left column.
REQ-014 gap_top  input  7  top row of the wall gap.
REQ-015 bird_y  output  7  bird top row, registered.
REQ-016 bird_vy  output  5  bird velocity, two's complement, positive is downward, registered.
REQ-017 state  output  2  IDLE=00, FLY=01, DEAD=10, registered.
REQ-018 collision  output  1  sticky hit flag, registered; this is the collision input to the game controller.

Function
REQ-019 The block SHALL register flap and produce flap_edge on each 0->1 transition.
REQ-020 In IDLE, the block SHALL hold bird_y=Y_START and bird_vy=0, and SHALL move to FLY on flap_edge without applying an impulse.
REQ-021 In FLY, a flap_edge SHALL set flap_pending; multiple edges between ticks SHALL collapse to one pending flap.
REQ-022 On frame_tick in FLY, bird_vy SHALL become -FLAP_IMPULSE if a flap is pending (including an edge in the same cycle), else min(bird_vy+GRAVITY, MAX_FALL_V), and flap_pending SHALL clear.
REQ-023 On the same tick, bird_y SHALL become bird_y + new bird_vy, computed in at least 9-bit signed arithmetic.
REQ-024 If the sum is at or above SCREEN_H-BIRD_H, the block SHALL set bird_y=SCREEN_H-BIRD_H and assert collision.
REQ-025 If the sum is below 0, behaviour SHALL follow REQ-036/037.
REQ-026 In FLY, a wall hit SHALL occur every cycle in which BIRD_X+3 >= wall_x, BIRD_X <= wall_x+3, and either bird_y < gap_top or bird_y+BIRD_H > gap_top+GAP_H.
REQ-027 A wall hit SHALL assert collision on the next clock edge.
REQ-028 When collision is asserted, state SHALL be DEAD in the same cycle; bird_y and bird_vy SHALL freeze.
REQ-029 collision SHALL remain 1 for as long as the block is in DEAD.
REQ-030 In DEAD, flap_edge SHALL return the block to IDLE with the REQ-020 values and collision=0.
REQ-031 frame_tick SHALL be ignored in IDLE and DEAD.
REQ-032 Encoding 11 is illegal and SHALL recover to IDLE on the next clock edge.

Reset
REQ-033 When resetn=0 at a clock edge, the block SHALL set state=IDLE, bird_y=Y_START, bird_vy=0, collision=0, flap_pending=0 and the flap register to 0.
REQ-034 Reset SHALL take priority over all events, including mid-flight and in DEAD.
REQ-035 Outputs SHALL reflect the reset values on the first edge after resetn falls.

Configuration
REQ-036 With CEILING_KILL_EN defined, a computed bird_y below 0 SHALL set bird_y=0 and assert collision.
REQ-037 Without CEILING_KILL_EN, a computed bird_y below 0 SHALL set bird_y=0 and bird_vy=0, with no collision.

Verification
REQ-038 Reset, flap pulse, then 3 ticks with no flap: state=FLY, bird_vy 1,2,3, bird_y 61,63,66.
REQ-039 From bird_y=66, bird_vy=3, two flap pulses then one tick: bird_vy=-6, bird_y=60; next tick: bird_vy=-5, bird_y=55.
REQ-040 Free fall from Y_START, no flaps: bird_y clamps at 116, collision=1, state=DEAD, values hold under further ticks.
REQ-041 wall_x=20, gap_top=40: at bird_y=60, collision stays 0; at bird_y=30, collision=1 one cycle later.
REQ-042 bird_y=3, flap then tick: with CEILING_KILL_EN, bird_y=0 and collision=1; without it, bird_y=0, bird_vy=0, state=FLY.
REQ-043 resetn=0 mid-flight at bird_y=90: next edge gives IDLE, bird_y=60, bird_vy=0, collision=0.
